algo_1rw_t1_bank_model: RTL and testbench
=========================================

Name: algo_1rw_t1_bank_model

Overview:
- Responder end of the t1 physical-memory interface driven by algo_mrnw1p_1rw_base_top.
- Models NUMVBNK independent single-port (1RW) SRAM banks.
- Accepts the t1_readA / t1_writeA / t1_addrA / t1_dinA / t1_bwA commands and returns t1_doutA after SRAM_DELAY cycles.
- Self-initializes its array after reset, checks protocol legality per bank, and is the memory the algorithm wrappers close against in simulation and emulation.

Parameters:
- NUMVBNK, 1, number of physical banks.
- NUMSROW, 4096, rows per bank.
- BITSROW, 12, row address width (2^BITSROW >= NUMSROW).
- PHYWDTH, 128, physical word width per bank.
- SRAM_DELAY, 1, read latency in cycles (>=1).
- INITVAL, 0, value written to every bit during initialization (0 or 1, replicated across PHYWDTH).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous active-high.
- ready  out  1  high once initialization sweep completes.
- t1_readA  in  NUMVBNK  per-bank read strobe.
- t1_writeA  in  NUMVBNK  per-bank write strobe.
- t1_addrA  in  NUMVBNK*BITSROW  per-bank row address, bank b at [b*BITSROW +: BITSROW].
- t1_dinA  in  NUMVBNK*PHYWDTH  per-bank write data.
- t1_bwA  in  NUMVBNK*PHYWDTH  per-bank bit-write enable (1 = bit written).
- t1_doutA  out  NUMVBNK*PHYWDTH  per-bank read data.
- t1_vldA  out  NUMVBNK  per-bank read-data-valid, aligned with t1_doutA.
- cmd_err  out  NUMVBNK  per-bank one-cycle protocol error pulse.

Behaviour:
- Reset (async assert, sync deassert internally via 2-flop sync):
  - ready=0, t1_doutA=0, t1_vldA=0, cmd_err=0.
  - Read pipeline cleared.
  - FSM in INIT with row counter=0.
  - Array contents are not reset directly.
- FSM: INIT -> DONE.
  - INIT writes INITVAL to row cnt of all banks each cycle, cnt++.
  - At cnt==NUMSROW-1 the write completes, FSM goes to DONE, and ready=1 the following cycle.
  - Initialization takes exactly NUMSROW cycles after reset deassertion.
  - DONE is terminal until rst.
- Reset asserted mid-INIT or mid-read: pipeline is flushed and the sweep restarts at row 0.
- Commands while ready=0: ignored (no array access, no t1_vldA); cmd_err pulses for any bank with read|write set.
- Write (ready=1, write=1, read=0, addr<NUMSROW):
  - mem[b][addr] = (mem & ~bw) | (din & bw), visible to a read issued the next cycle or later.
  - bw all-zero is a legal no-op.
- Read (ready=1, read=1, write=0, addr<NUMSROW):
  - Data mem[b][addr] sampled at the command edge.
  - t1_doutA[b] and t1_vldA[b]=1 appear SRAM_DELAY cycles after the command cycle.
  - Fully pipelined: one read per bank per cycle.
- Between reads, t1_doutA[b] holds the last returned value; t1_vldA[b]=0.
- Read and write to the same bank in the same cycle (1RW violation):
  - Neither is performed.
  - cmd_err[b] pulses the next cycle.
  - No t1_vldA for that slot.
- addr >= NUMSROW with read or write: command dropped, cmd_err[b] pulses.
- Banks are fully independent; commands to different banks in the same cycle are legal.
- cmd_err is registered: it pulses exactly one cycle after the offending command.

Decomposition:
- Shared package algo_t1_model_pkg:
  - FSM state encoding (INIT, DONE).
  - Localparam for reset-synchronizer depth.
  - Helper function for the bank slice offset.
- Top module holds the FSM, row counter, and reset synchronizer.
- One sub-module, algo_1rw_t1_bank, instantiated NUMVBNK times in a generate loop. Each instance contains:
  - the storage array and bit-write merge;
  - legality check;
  - SRAM_DELAY-deep data/valid shift pipeline.

Test Plan:
- Init: NUMSROW=16, SRAM_DELAY=2, INITVAL=1. Release rst; ready rises exactly 16 cycles later (+sync). Read row 5 -> t1_doutA=all-ones, t1_vldA high 2 cycles after the command.
- Bit-write: write row 3 with din=0xFFFF...FF and bw=0x00FF; then read row 3. With INITVAL=0, expect dout=0x00FF and t1_vldA=1 at +SRAM_DELAY.
- Back-to-back reads: write rows 0..3 with values 0xA0..0xA3, then read rows 0..3 on consecutive cycles. Expect dout 0xA0..0xA3 on consecutive cycles starting at +SRAM_DELAY, with t1_vldA high for 4 cycles.
- Collision: read and write to bank 0 row 7 in the same cycle. Expect cmd_err[0]=1 for one cycle, no t1_vldA, and row 7 unchanged on a later read. Bank 1 traffic in the same cycle completes normally.
- Out-of-range / early commands:
  - Read at addr=NUMSROW (e.g. 16) -> cmd_err pulse, no valid.
  - Any command issued during INIT -> cmd_err pulse, array unaffected.
- Reset mid-operation: assert rst with a read in flight at SRAM_DELAY=3. Outputs go to 0 immediately, no t1_vldA emerges afterwards, and ready returns only after a full re-sweep of NUMSROW cycles.

Source files
------------

// File: rtl/algo_t1_model_pkg.sv
// -----------------------------------------------------------------------------
// algo_t1_model_pkg
// Shared definitions for the t1 1RW bank model: init FSM encoding, reset
// synchronizer depth and small helpers for bank slicing and row-index width.
// -----------------------------------------------------------------------------
package algo_t1_model_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  localparam int unsigned RST_SYNC_DEPTH = 2;

  // Bit offset of bank `bank` inside a flat per-bank bus of `width` bits each.
  function automatic int unsigned bank_ofs(input int unsigned bank,
                                           input int unsigned width);
    return bank * width;
  endfunction

  // Index width needed to address `rows` storage rows (at least 1 bit).
  function automatic int unsigned row_aw(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/algo_1rw_t1_bank.sv
// -----------------------------------------------------------------------------
// algo_1rw_t1_bank
// One single-port (1RW) SRAM bank: storage array with bit-write merge,
// command legality check and a SRAM_DELAY-deep read-return pipeline.
//
// Ports:
//   clk, rst        clock / internal (synchronized) active-high async reset
//   ready           array initialized; commands are accepted only when high
//   init_we/row     initialization sweep write (INITVAL to row init_row)
//   rd, wr, addr    read / write strobes and row address
//   din, bw         write data and bit-write enable (1 = bit written)
//   dout, vld       read data and its valid, SRAM_DELAY cycles after command
//   cmd_err         registered one-cycle pulse for an illegal command
// -----------------------------------------------------------------------------
module algo_1rw_t1_bank
  import algo_t1_model_pkg::*;
#(
  parameter int unsigned NUMSROW    = 4096,
  parameter int unsigned BITSROW    = 12,
  parameter int unsigned PHYWDTH    = 128,
  parameter int unsigned SRAM_DELAY = 1,
  parameter int unsigned INITVAL    = 0,
  localparam int unsigned AW        = row_aw(NUMSROW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               init_we,
  input  logic [AW-1:0]      init_row,
  input  logic               rd,
  input  logic               wr,
  input  logic [BITSROW-1:0] addr,
  input  logic [PHYWDTH-1:0] din,
  input  logic [PHYWDTH-1:0] bw,
  output logic [PHYWDTH-1:0] dout,
  output logic               vld,
  output logic               cmd_err
);

  localparam logic INIT_BIT = (INITVAL != 0);

  logic [PHYWDTH-1:0] mem [NUMSROW];

  logic               legal;
  logic               do_rd;
  logic               do_wr;
  logic [AW-1:0]      row;
  logic [PHYWDTH-1:0] rd_data;

  logic                                cmd_err_d, cmd_err_q;
  logic [SRAM_DELAY-1:0]               vld_d, vld_q;
  logic [SRAM_DELAY-1:0][PHYWDTH-1:0]  data_d, data_q;

  // Legal only after init, with exactly one of rd/wr, and an in-range row.
  always_comb begin
    row       = addr[AW-1:0];
    legal     = ready && !(rd && wr) && (32'(addr) < NUMSROW);
    do_rd     = rd && legal;
    do_wr     = wr && legal;
    rd_data   = mem[row];
    cmd_err_d = (rd || wr) && !legal;
  end

  // Storage has no reset; the init sweep in the top fills it after reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_row] <= {PHYWDTH{INIT_BIT}};
    end else if (do_wr) begin
      mem[row] <= (mem[row] & ~bw) | (din & bw);
    end
  end

  // Each stage loads only when valid data arrives, so the last stage holds
  // the most recently returned word between reads.
  always_comb begin
    vld_d     = '0;
    data_d    = data_q;
    vld_d[0]  = do_rd;
    if (do_rd) data_d[0] = rd_data;
    for (int i = 1; i < SRAM_DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      data_q    <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      data_q    <= data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign dout    = data_q[SRAM_DELAY-1];
  assign vld     = vld_q[SRAM_DELAY-1];
  assign cmd_err = cmd_err_q;

endmodule

// File: rtl/algo_1rw_t1_bank_model.sv
// -----------------------------------------------------------------------------
// algo_1rw_t1_bank_model
// Responder side of the t1 physical-memory interface: NUMVBNK independent
// 1RW SRAM banks, self-initialized to INITVAL after reset.
//
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   ready        high once the initialization sweep has completed
//   t1_readA     per-bank read strobe
//   t1_writeA    per-bank write strobe
//   t1_addrA     per-bank row address (bank b at [b*BITSROW +: BITSROW])
//   t1_dinA      per-bank write data
//   t1_bwA       per-bank bit-write enable
//   t1_doutA     per-bank read data
//   t1_vldA      per-bank read-data valid
//   cmd_err      per-bank one-cycle protocol error pulse
//
// Init FSM:
//   state | meaning
//   INIT  | sweeping INITVAL into row cnt of every bank, one row per cycle
//   DONE  | array initialized, ready=1, commands accepted (terminal until rst)
// -----------------------------------------------------------------------------
module algo_1rw_t1_bank_model
  import algo_t1_model_pkg::*;
#(
  parameter int unsigned NUMVBNK    = 1,
  parameter int unsigned NUMSROW    = 4096,
  parameter int unsigned BITSROW    = 12,
  parameter int unsigned PHYWDTH    = 128,
  parameter int unsigned SRAM_DELAY = 1,
  parameter int unsigned INITVAL    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMVBNK-1:0]         t1_readA,
  input  logic [NUMVBNK-1:0]         t1_writeA,
  input  logic [NUMVBNK*BITSROW-1:0] t1_addrA,
  input  logic [NUMVBNK*PHYWDTH-1:0] t1_dinA,
  input  logic [NUMVBNK*PHYWDTH-1:0] t1_bwA,
  output logic [NUMVBNK*PHYWDTH-1:0] t1_doutA,
  output logic [NUMVBNK-1:0]         t1_vldA,
  output logic [NUMVBNK-1:0]         cmd_err
);

  localparam int unsigned AW = row_aw(NUMSROW);

  logic [RST_SYNC_DEPTH-1:0] rst_sync_d, rst_sync_q;
  logic                      rst_i;
  logic [0:0]                state_d, state_q;
  logic [AW-1:0]             cnt_d, cnt_q;
  logic                      ready_d, ready_q;
  logic                      init_we;

  // Reset asserts immediately and releases two clocks after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= '1;
    else     rst_sync_q <= rst_sync_d;
  end

  assign rst_i = rst_sync_q[RST_SYNC_DEPTH-1];

  always_comb begin
    rst_sync_d = {rst_sync_q[RST_SYNC_DEPTH-2:0], 1'b0};
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    init_we    = 1'b0;
    if (state_q == ST_INIT && !rst_i) begin
      init_we = 1'b1;
      if (cnt_q == AW'(NUMSROW - 1)) begin
        state_d = ST_DONE;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

  for (genvar b = 0; b < NUMVBNK; b++) begin : g_bank
    algo_1rw_t1_bank #(
      .NUMSROW    (NUMSROW),
      .BITSROW    (BITSROW),
      .PHYWDTH    (PHYWDTH),
      .SRAM_DELAY (SRAM_DELAY),
      .INITVAL    (INITVAL)
    ) u_bank (
      .clk      (clk),
      .rst      (rst_i),
      .ready    (ready_q),
      .init_we  (init_we),
      .init_row (cnt_q),
      .rd       (t1_readA[b]),
      .wr       (t1_writeA[b]),
      .addr     (t1_addrA[bank_ofs(b, BITSROW) +: BITSROW]),
      .din      (t1_dinA[bank_ofs(b, PHYWDTH) +: PHYWDTH]),
      .bw       (t1_bwA[bank_ofs(b, PHYWDTH) +: PHYWDTH]),
      .dout     (t1_doutA[bank_ofs(b, PHYWDTH) +: PHYWDTH]),
      .vld      (t1_vldA[b]),
      .cmd_err  (cmd_err[b])
    );
  end

endmodule

// File: tb/tb_algo_1rw_t1_bank_model.sv
module tb_algo_1rw_t1_bank_model;

  localparam int NB = 2;
  localparam int NR = 16;
  localparam int BR = 5;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int IV = 1;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready;
  logic [NB-1:0]    rd_v, wr_v;
  logic [NB*BR-1:0] addr_v;
  logic [NB*W-1:0]  din_v, bw_v;
  logic [NB*W-1:0]  dout;
  logic [NB-1:0]    vld, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  algo_1rw_t1_bank_model #(
    .NUMVBNK(NB), .NUMSROW(NR), .BITSROW(BR), .PHYWDTH(W),
    .SRAM_DELAY(D), .INITVAL(IV)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .t1_readA(rd_v), .t1_writeA(wr_v), .t1_addrA(addr_v),
    .t1_dinA(din_v), .t1_bwA(bw_v),
    .t1_doutA(dout), .t1_vldA(vld), .cmd_err(err)
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem    [NB][NR];
  logic [W-1:0] due_data [NB][8];
  logic         due_vld  [NB][8];
  logic         exp_ready = 1'b0;
  logic [NB-1:0] exp_vld = '0;
  logic [NB-1:0] exp_err = '0;
  logic [W-1:0] exp_dout [NB];
  int  edges_since_rst;
  int  tcount = 0;
  bit  accept, m_rd, m_wr, m_legal;
  int  m_a, m_slot;
  logic [W-1:0] m_din, m_bw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges_since_rst = 0;
      exp_ready = 1'b0;
      exp_vld   = '0;
      exp_err   = '0;
      for (int b = 0; b < NB; b++) begin
        exp_dout[b] = '0;
        for (int s = 0; s < 8; s++) due_vld[b][s] = 1'b0;
      end
    end else begin
      accept = (edges_since_rst >= SYNC + NR);
      if (edges_since_rst < 1000) edges_since_rst++;
      for (int b = 0; b < NB; b++) begin
        m_rd  = rd_v[b];
        m_wr  = wr_v[b];
        m_a   = int'(addr_v[b*BR +: BR]);
        m_din = din_v[b*W +: W];
        m_bw  = bw_v[b*W +: W];
        m_legal = accept && !(m_rd && m_wr) && (m_a < NR);
        exp_err[b] = (m_rd || m_wr) && !m_legal;
        if (m_legal && m_rd) begin
          due_vld[b][(tcount + D - 1) % 8]  = 1'b1;
          due_data[b][(tcount + D - 1) % 8] = m_mem[b][m_a];
        end
        if (m_legal && m_wr) m_mem[b][m_a] = (m_mem[b][m_a] & ~m_bw) | (m_din & m_bw);
        m_slot = tcount % 8;
        exp_vld[b] = due_vld[b][m_slot];
        if (due_vld[b][m_slot]) exp_dout[b] = due_data[b][m_slot];
        due_vld[b][m_slot] = 1'b0;
      end
      if (edges_since_rst == SYNC + NR) begin
        exp_ready = 1'b1;
        for (int b = 0; b < NB; b++)
          for (int r = 0; r < NR; r++) m_mem[b][r] = {W{IV[0]}};
      end
      tcount++;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ready", W'(ready), W'(exp_ready));
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("b%0d vld", b), W'(vld[b]), W'(exp_vld[b]));
      chk($sformatf("b%0d cmd_err", b), W'(err[b]), W'(exp_err[b]));
      chk($sformatf("b%0d dout", b), dout[b*W +: W], exp_dout[b]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_v = '0; wr_v = '0; addr_v = '0; din_v = '0; bw_v = '0;
  endtask

  task automatic set_cmd(input int b, input logic r, input logic w,
                         input logic [BR-1:0] a, input logic [W-1:0] d,
                         input logic [W-1:0] m);
    rd_v[b] = r; wr_v[b] = w;
    addr_v[b*BR +: BR] = a;
    din_v[b*W +: W] = d;
    bw_v[b*W +: W] = m;
  endtask

  task automatic write_row(input int b, input logic [BR-1:0] a,
                           input logic [W-1:0] d, input logic [W-1:0] m);
    idle();
    set_cmd(b, 1'b0, 1'b1, a, d, m);
    step(1);
    idle();
  endtask

  task automatic read_chk(input string nm, input int b, input logic [BR-1:0] a,
                          input logic [W-1:0] exp);
    idle();
    set_cmd(b, 1'b1, 1'b0, a, '0, '0);
    step(1);
    idle();
    step(D - 1);
    chk({nm, " vld"}, W'(vld[b]), 16'd1);
    chk({nm, " dout"}, dout[b*W +: W], exp);
  endtask

  // Releases rst and returns the posedge index at which ready was first seen.
  task automatic release_and_wait(output int k_ready, input bit early_cmd);
    k_ready = 0;
    rst = 1'b0;
    for (int k = 1; k <= 100 && k_ready == 0; k++) begin
      step(1);
      if (early_cmd && k == 4) set_cmd(0, 1'b0, 1'b1, 5'd9, 16'h0000, 16'hFFFF);
      if (early_cmd && k == 5) begin
        chk("early write cmd_err", W'(err), 16'h0001);
        idle();
      end
      if (ready) k_ready = k;
    end
  endtask

  int k_ready;

  initial begin
    idle();
    rst = 1'b1;
    step(3);

    release_and_wait(k_ready, 1'b1);
    chk("ready latency", 16'(k_ready), 16'd18);

    read_chk("init row5", 0, 5'd5, 16'hFFFF);
    read_chk("init b1 row5", 1, 5'd5, 16'hFFFF);
    read_chk("row9 untouched by early write", 0, 5'd9, 16'hFFFF);

    write_row(0, 5'd3, 16'h0000, 16'hFFFF);
    write_row(0, 5'd3, 16'hFFFF, 16'h00FF);
    read_chk("bit-write", 0, 5'd3, 16'h00FF);
    write_row(0, 5'd3, 16'h0000, 16'h0000);
    read_chk("bw zero no-op", 0, 5'd3, 16'h00FF);

    for (int i = 0; i < 4; i++) write_row(0, BR'(i), 16'h00A0 + 16'(i), 16'hFFFF);
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_cmd(0, 1'b1, 1'b0, BR'(i), '0, '0);
      else idle();
      step(1);
      if (i >= 1) begin
        chk($sformatf("b2b vld %0d", i - 1), W'(vld[0]), 16'd1);
        chk($sformatf("b2b dout %0d", i - 1), dout[W-1:0], 16'h00A0 + 16'(i - 1));
      end
    end
    step(1);
    chk("b2b vld drop", W'(vld[0]), 16'd0);
    chk("b2b dout hold", dout[W-1:0], 16'h00A3);

    idle();
    set_cmd(0, 1'b1, 1'b1, 5'd7, 16'h0000, 16'hFFFF);
    set_cmd(1, 1'b0, 1'b1, 5'd7, 16'h1234, 16'hFFFF);
    step(1);
    idle();
    chk("collision cmd_err", W'(err), 16'h0001);
    step(1);
    chk("collision no vld", W'(vld[0]), 16'd0);
    chk("collision err clears", W'(err), 16'h0000);
    read_chk("collision row7 unchanged", 0, 5'd7, 16'hFFFF);
    read_chk("b1 write alongside", 1, 5'd7, 16'h1234);

    idle();
    set_cmd(1, 1'b1, 1'b0, 5'd16, '0, '0);
    step(1);
    idle();
    chk("oor read cmd_err", W'(err), 16'h0002);
    step(1);
    chk("oor read no vld", W'(vld[1]), 16'd0);
    write_row(0, 5'd31, 16'h0000, 16'hFFFF);
    chk("oor write cmd_err", W'(err), 16'h0001);

    step(2);
    idle();
    set_cmd(0, 1'b1, 1'b0, 5'd5, '0, '0);
    step(1);
    idle();
    rst = 1'b1;
    #1;
    chk("rst dout zero", dout[W-1:0], 16'h0000);
    chk("rst vld zero", W'(vld), 16'h0000);
    chk("rst ready zero", W'(ready), 16'h0000);
    step(2);
    release_and_wait(k_ready, 1'b0);
    chk("re-sweep latency", 16'(k_ready), 16'd18);
    read_chk("row3 re-initialized", 0, 5'd3, 16'hFFFF);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
